branch_resolve_unit: RTL

- Update-side companion to the 2-bit saturating direction predictor.
- Queues each fetch-time prediction (PC, predicted direction, predicted target) in order until the branch resolves in execute.
- Compares the actual outcome with the queued prediction, raises a one-cycle mispredict/redirect, and drives the taken/not-taken training input back to the predictor.

---
 rtl/branch_resolve_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Holds in-flight branch predictions in order, resolves the oldest against execute, pulses mispredict/redirect and trains the predictor.
// Define BRANCH_RESOLVE_STATS_EN to add saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  output logic                     mispredict,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_idx,
  output logic                     upd_taken,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow_err
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispredicts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [PC_W-1:0] pc_mem  [DEPTH];
  logic            tk_mem  [DEPTH];
  logic [PC_W-1:0] tgt_mem [DEPTH];

  logic [AW:0] rd_q, rd_d, wr_q, wr_d;
  logic        empty, full, resolve, push, flush;
  logic        dir_miss, tgt_miss, miss;
  logic [PC_W-1:0] head_pc, head_tgt, redirect_d;
  logic            head_tk;

  logic              mispredict_q, upd_valid_q, upd_taken_q, underflow_q;
  logic [PC_W-1:0]   redirect_q;
  logic [IDX_W-1:0]  upd_idx_q;

  assign empty      = (rd_q == wr_q);
  assign full       = (rd_q[AW] != wr_q[AW]) && (rd_q[AW-1:0] == wr_q[AW-1:0]);
  assign pred_ready = !full;
  assign count      = wr_q - rd_q;

  assign head_pc  = pc_mem[rd_q[AW-1:0]];
  assign head_tk  = tk_mem[rd_q[AW-1:0]];
  assign head_tgt = tgt_mem[rd_q[AW-1:0]];

  assign resolve  = res_valid && !empty;
  assign dir_miss = (head_tk != res_taken);
  assign tgt_miss = head_tk && res_taken && (head_tgt != res_target);
  assign miss     = dir_miss | tgt_miss;
  assign flush    = resolve && miss;
  // A push racing a flush is on the wrong path and must not enter the queue.
  assign push     = pred_valid && pred_ready && !flush;

  assign redirect_d = res_taken ? res_target : head_pc + PC_W'(4);

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    if (flush) begin
      rd_d = rd_q + PTR_ONE;
      wr_d = rd_q + PTR_ONE;
    end else begin
      if (resolve) rd_d = rd_q + PTR_ONE;
      if (push)    wr_d = wr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q[AW-1:0]]  <= pred_pc;
      tk_mem[wr_q[AW-1:0]]  <= pred_taken;
      tgt_mem[wr_q[AW-1:0]] <= pred_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_q <= 1'b0;
      upd_valid_q  <= 1'b0;
      upd_taken_q  <= 1'b0;
      upd_idx_q    <= '0;
      redirect_q   <= '0;
      underflow_q  <= 1'b0;
    end else begin
      upd_valid_q  <= resolve;
      mispredict_q <= flush;
      if (resolve) begin
        upd_idx_q   <= head_pc[IDX_W+1:2];
        upd_taken_q <= res_taken;
      end
      if (flush) redirect_q <= redirect_d;
      if (res_valid && empty) underflow_q <= 1'b1;
    end
  end

  assign mispredict    = mispredict_q;
  assign upd_valid     = upd_valid_q;
  assign upd_taken     = upd_taken_q;
  assign upd_idx       = upd_idx_q;
  assign redirect_pc   = redirect_q;
  assign underflow_err = underflow_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (resolve && (stat_br_q != 32'hFFFF_FFFF)) stat_br_q <= stat_br_q + 32'd1;
      if (flush && (stat_mp_q != 32'hFFFF_FFFF))   stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule
